// File: rtl/classifier_argmax_selector.sv
// Argmax over one frame of per-class scores; the winning class index is held
// for the seven-segment display and reported with its score and a done pulse.
module classifier_argmax_selector #(
  parameter int NUM_CLASSES = 10,
  parameter int SCORE_WIDTH = 8,
  parameter int INDEX_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   score_valid,
  input  logic [SCORE_WIDTH-1:0] score_data,
  output logic                   busy,
  output logic                   result_valid,
  output logic [INDEX_WIDTH-1:0] result_class,
  output logic [SCORE_WIDTH-1:0] result_score,
  output logic [7:0]             integer_to_be_displayed,
  output logic [1:0]             state_dbg
);

  // Handshake: a score is taken on a rising clk edge where the block is in
  // COLLECT and score_valid=1; there is no ready, scores outside a frame are dropped.

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(NUM_CLASSES - 1);

  state_t                 state, state_next;
  logic [INDEX_WIDTH-1:0] count;
  logic [INDEX_WIDTH-1:0] best_idx, next_idx;
  logic [SCORE_WIDTH-1:0] best_score, next_score;
  logic                   accept, last, take;

  always_comb begin
    state_next = state;
    accept     = (state == COLLECT) && score_valid;
    last       = (count == LAST_IDX);
    // Strict compare keeps the lower index on ties; class 0 always loads.
    take       = accept && ((count == '0) || (score_data > best_score));
    next_idx   = take ? count : best_idx;
    next_score = take ? score_data : best_score;

    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: if (accept && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy         = (state == COLLECT);
  assign result_valid = (state == DONE);
  assign state_dbg    = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state                   <= IDLE;
      count                   <= '0;
      best_idx                <= '0;
      best_score              <= '0;
      result_class            <= '0;
      result_score            <= '0;
      integer_to_be_displayed <= '0;
    end else begin
      state <= state_next;
      if (state == IDLE && start) begin
        count <= '0;
      end
      if (accept) begin
        count      <= last ? '0 : count + INDEX_WIDTH'(1);
        best_idx   <= next_idx;
        best_score <= next_score;
      end
      // Result registers load on the final accept so they are visible in DONE.
      if (accept && last) begin
        result_class            <= next_idx;
        result_score            <= next_score;
        integer_to_be_displayed <= 8'(next_idx);
      end
    end
  end

endmodule

// File: tb/tb_classifier_argmax_selector.sv
// Bench for classifier_argmax_selector: randomized frames checked against an
// argmax reference computed directly from the accepted score list.
module tb_classifier_argmax_selector;

  localparam int N  = 10;
  localparam int SW = 8;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          score_valid = 1'b0;
  logic [SW-1:0] score_data = '0;
  logic          busy;
  logic          result_valid;
  logic [IW-1:0] result_class;
  logic [SW-1:0] result_score;
  logic [7:0]    integer_to_be_displayed;
  logic [1:0]    state_dbg;

  int checks = 0;
  int errors = 0;
  int rv_count = 0;

  classifier_argmax_selector #(.NUM_CLASSES(N), .SCORE_WIDTH(SW), .INDEX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset), .start(start), .score_valid(score_valid),
    .score_data(score_data), .busy(busy), .result_valid(result_valid),
    .result_class(result_class), .result_score(result_score),
    .integer_to_be_displayed(integer_to_be_displayed), .state_dbg(state_dbg)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (result_valid) rv_count++;
  end

  // Reference model: first index holding the largest value
  function automatic int ref_class(input int s[N]);
    int best = 0;
    for (int k = 1; k < N; k++) if (s[k] > s[best]) best = k;
    return best;
  endfunction

  function automatic int ref_score(input int s[N]);
    int m = 0;
    for (int k = 0; k < N; k++) if (s[k] > m) m = s[k];
    return m;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: one full frame; gaps of score_valid=0 up to gap_max before each
  // score, optional stray start pulse inside the frame. Returns observations.
  task automatic drive_frame(input int s[N], input int gap_max, input bit bad_start,
                             output logic busy_seen, output logic rv_seen,
                             output logic done_busy);
    int ng;
    start = 1'b1; score_valid = 1'b0;
    tick();
    start = 1'b0;
    busy_seen = busy;
    for (int k = 0; k < N; k++) begin
      ng = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
      if (bad_start && k == 5 && ng == 0) ng = 1;
      for (int g = 0; g < ng; g++) begin
        score_valid = 1'b0;
        score_data  = SW'($urandom);
        start       = bad_start && (k == 5) && (g == 0);
        tick();
      end
      start       = 1'b0;
      score_valid = 1'b1;
      score_data  = SW'(s[k]);
      tick();
    end
    score_valid = 1'b0;
    rv_seen   = result_valid;
    done_busy = busy;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv got=%0b exp=0", result_valid); end
    checks++; if (result_class !== '0) begin errors++; $display("FAIL reset_class got=%0d exp=0", result_class); end
    checks++; if (result_score !== '0) begin errors++; $display("FAIL reset_score got=%0d exp=0", result_score); end
    checks++; if (integer_to_be_displayed !== 8'd0) begin errors++; $display("FAIL reset_disp got=%0d exp=0", integer_to_be_displayed); end
    rv_count = 0;
    for (int i = 0; i < 8; i++) begin
      score_valid = 1'($urandom);
      score_data  = SW'($urandom);
      tick();
    end
    score_valid = 1'b0;
    tick(); tick();
    checks++; if (rv_count !== 0) begin errors++; $display("FAIL idle_scores_rv got=%0d exp=0", rv_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_normal();
    int s[N] = '{3, 9, 1, 200, 7, 0, 5, 4, 8, 2};
    logic b, rv, db;
    rv_count = 0;
    drive_frame(s, 0, 1'b0, b, rv, db);
    checks++; if (b !== 1'b1) begin errors++; $display("FAIL normal_busy got=%0b exp=1", b); end
    checks++; if (rv !== 1'b1) begin errors++; $display("FAIL normal_latency got=%0b exp=1", rv); end
    checks++; if (db !== 1'b0) begin errors++; $display("FAIL normal_done_busy got=%0b exp=0", db); end
    checks++; if (rv_count !== 1) begin errors++; $display("FAIL normal_pulses got=%0d exp=1", rv_count); end
    checks++; if (result_class !== 4'd3) begin errors++; $display("FAIL normal_class got=%0d exp=3", result_class); end
    checks++; if (result_score !== 8'd200) begin errors++; $display("FAIL normal_score got=%0d exp=200", result_score); end
    checks++; if (integer_to_be_displayed !== 8'd3) begin errors++; $display("FAIL normal_disp got=%0d exp=3", integer_to_be_displayed); end
  endtask

  task automatic test_ties();
    int a[N] = '{50, 50, 50, 50, 50, 50, 50, 50, 50, 50};
    int c[N] = '{10, 10, 10, 10, 10, 10, 10, 10, 90, 90};
    logic b, rv, db;
    drive_frame(a, 0, 1'b0, b, rv, db);
    checks++; if (result_class !== 4'd0) begin errors++; $display("FAIL tie_all_class got=%0d exp=0", result_class); end
    checks++; if (result_score !== 8'd50) begin errors++; $display("FAIL tie_all_score got=%0d exp=50", result_score); end
    drive_frame(c, 0, 1'b0, b, rv, db);
    checks++; if (result_class !== 4'd8) begin errors++; $display("FAIL tie_last_class got=%0d exp=8", result_class); end
    checks++; if (result_score !== 8'd90) begin errors++; $display("FAIL tie_last_score got=%0d exp=90", result_score); end
  endtask

  task automatic test_stalls();
    int s[N];
    logic b, rv, db;
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < N; k++) s[k] = (f % 3 == 0) ? $urandom_range(0, 3) : $urandom_range(0, 255);
      rv_count = 0;
      drive_frame(s, 3, (f % 2) == 1, b, rv, db);
      checks++; if (rv !== 1'b1) begin errors++; $display("FAIL stall_latency f=%0d got=%0b exp=1", f, rv); end
      checks++; if (rv_count !== 1) begin errors++; $display("FAIL stall_pulses f=%0d got=%0d exp=1", f, rv_count); end
      checks++; if (result_class !== IW'(ref_class(s))) begin errors++; $display("FAIL stall_class f=%0d got=%0d exp=%0d", f, result_class, ref_class(s)); end
      checks++; if (result_score !== SW'(ref_score(s))) begin errors++; $display("FAIL stall_score f=%0d got=%0d exp=%0d", f, result_score, ref_score(s)); end
      checks++; if (integer_to_be_displayed !== 8'(ref_class(s))) begin errors++; $display("FAIL stall_disp f=%0d got=%0d exp=%0d", f, integer_to_be_displayed, ref_class(s)); end
    end
  endtask

  task automatic test_reset_mid_frame();
    int s[N] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 255};
    logic b, rv, db;
    rv_count = 0;
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      score_valid = 1'b1; score_data = 8'd250; tick();
    end
    score_valid = 1'b0;
    reset = 1'b1; tick(); reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
    checks++; if (integer_to_be_displayed !== 8'd0) begin errors++; $display("FAIL midrst_disp got=%0d exp=0", integer_to_be_displayed); end
    checks++; if (result_score !== 8'd0) begin errors++; $display("FAIL midrst_score got=%0d exp=0", result_score); end
    drive_frame(s, 1, 1'b0, b, rv, db);
    checks++; if (rv_count !== 1) begin errors++; $display("FAIL midrst_pulses got=%0d exp=1", rv_count); end
    checks++; if (result_class !== 4'd9) begin errors++; $display("FAIL midrst_class got=%0d exp=9", result_class); end
    checks++; if (result_score !== 8'd255) begin errors++; $display("FAIL midrst_result_score got=%0d exp=255", result_score); end
  endtask

  task automatic test_hold();
    int s[N] = '{0, 0, 0, 0, 0, 0, 77, 0, 0, 0};
    int unstable = 0;
    logic b, rv, db;
    for (int i = 0; i < 100; i++) begin
      score_valid = 1'($urandom); score_data = SW'($urandom);
      tick();
      if (integer_to_be_displayed !== 8'd9 || result_score !== 8'd255) unstable++;
    end
    score_valid = 1'b0;
    checks++; if (unstable !== 0) begin errors++; $display("FAIL hold_stable got=%0d changes exp=0", unstable); end
    drive_frame(s, 0, 1'b0, b, rv, db);
    checks++; if (integer_to_be_displayed !== 8'd6) begin errors++; $display("FAIL hold_update got=%0d exp=6", integer_to_be_displayed); end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_ties();
    test_stalls();
    test_reset_mid_frame();
    test_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
